// File: rtl/arbitro_hierarquia_memoria.sv
// Two-port round-robin arbiter that serialises fetch/data requests onto the
// single memory-hierarchy port, returns a done pulse and keeps hit/miss stats.
module arbitro_hierarquia_memoria #(
  parameter int ACCESS_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [5:0]       addr0,
  input  logic [5:0]       addr1,
  input  logic [15:0]      wdata0,
  input  logic [15:0]      wdata1,
  output logic             done0,
  output logic             done1,
  output logic [15:0]      rdata,
  output logic             last_hit_L1,
  output logic             last_hit_L2,
  output logic             busy,
  output logic [5:0]       mem_address,
  output logic [15:0]      mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [15:0]      mem_read_data,
  input  logic             mem_hit_L1,
  input  logic             mem_hit_L2,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] cnt_hit_L1,
  output logic [CNT_W-1:0] cnt_hit_L2,
  output logic [CNT_W-1:0] cnt_miss
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  localparam int              CW       = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state, w_next;
  logic             r_rr, r_grant;
  logic [CW-1:0]    r_cnt;
  logic [5:0]       r_addr;
  logic [15:0]      r_wdata, r_rdata;
  logic             r_rd, r_wr, r_hit_l1, r_hit_l2;
  logic [CNT_W-1:0] r_cnt_l1, r_cnt_l2, r_cnt_miss;

  logic w_both, w_grant_idx, w_start, w_finish;

  assign w_both      = req0 & req1;
  assign w_grant_idx = w_both ? ~r_rr : req1;
  assign w_start     = (r_state == S_IDLE) && (req0 || req1);
  assign w_finish    = (r_state == S_ISSUE) && (r_cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req0 || req1) w_next = S_ISSUE;
      S_ISSUE: if (r_cnt == '0)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the asynchronous reset clears r_rd/r_wr at once, so an in-flight
  // access is abandoned without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr     <= 1'b1;
      r_grant  <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_hit_l1 <= 1'b0;
      r_hit_l2 <= 1'b0;
    end else if (w_start) begin
      r_grant <= w_grant_idx;
      if (w_both) r_rr <= w_grant_idx;
      r_addr  <= w_grant_idx ? addr1  : addr0;
      r_wdata <= w_grant_idx ? wdata1 : wdata0;
      r_rd    <= w_grant_idx ? ~we1   : ~we0;
      r_wr    <= w_grant_idx ? we1    : we0;
      r_cnt   <= CNT_LOAD;
    end else if (w_finish) begin
      if (r_rd) r_rdata <= mem_read_data;
      r_hit_l1 <= mem_hit_L1;
      r_hit_l2 <= mem_hit_L2;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Saturating statistics; a clear in the same cycle as a completion wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt_l1   <= '0;
      r_cnt_l2   <= '0;
      r_cnt_miss <= '0;
    end else if (clear_cnt) begin
      r_cnt_l1   <= '0;
      r_cnt_l2   <= '0;
      r_cnt_miss <= '0;
    end else if (w_finish) begin
      if (mem_hit_L1) begin
        if (r_cnt_l1 != CNT_MAX) r_cnt_l1 <= r_cnt_l1 + CNT_W'(1);
      end else if (mem_hit_L2) begin
        if (r_cnt_l2 != CNT_MAX) r_cnt_l2 <= r_cnt_l2 + CNT_W'(1);
      end else begin
        if (r_cnt_miss != CNT_MAX) r_cnt_miss <= r_cnt_miss + CNT_W'(1);
      end
    end
  end

  assign done0          = (r_state == S_DONE) && !r_grant;
  assign done1          = (r_state == S_DONE) &&  r_grant;
  assign busy           = (r_state != S_IDLE);
  assign rdata          = r_rdata;
  assign last_hit_L1    = r_hit_l1;
  assign last_hit_L2    = r_hit_l2;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_read       = r_rd;
  assign mem_write      = r_wr;
  assign cnt_hit_L1     = r_cnt_l1;
  assign cnt_hit_L2     = r_cnt_l2;
  assign cnt_miss       = r_cnt_miss;

endmodule

// File: tb/tb_arbitro_hierarquia_memoria.sv
// Directed bench: instance A (1-cycle access) talks to a small hierarchy model,
// instance B (3-cycle access, 2-bit counters) covers saturation and mid-access reset.
module tb_arbitro_hierarquia_memoria;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic        a_req0, a_req1, a_we0, a_we1, a_clr;
  logic [5:0]  a_addr0, a_addr1, a_maddr;
  logic [15:0] a_wdata0, a_wdata1, a_rdata, a_mwdata, a_mrdata;
  logic        a_done0, a_done1, a_hl1, a_hl2, a_busy, a_mrd, a_mwr, a_mh1, a_mh2;
  logic [7:0]  a_c1, a_c2, a_cm;

  // Instance B signals
  logic        b_req0, b_req1, b_we0, b_we1, b_clr;
  logic [5:0]  b_addr0, b_addr1, b_maddr;
  logic [15:0] b_wdata0, b_wdata1, b_rdata, b_mwdata, b_mrdata;
  logic        b_done0, b_done1, b_hl1, b_hl2, b_busy, b_mrd, b_mwr, b_mh1, b_mh2;
  logic [1:0]  b_c1, b_c2, b_cm;

  arbitro_hierarquia_memoria #(.ACCESS_CYCLES(1), .CNT_W(8)) u_a (
    .clock(clock), .reset(reset),
    .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
    .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
    .done0(a_done0), .done1(a_done1), .rdata(a_rdata),
    .last_hit_L1(a_hl1), .last_hit_L2(a_hl2), .busy(a_busy),
    .mem_address(a_maddr), .mem_write_data(a_mwdata),
    .mem_read(a_mrd), .mem_write(a_mwr), .mem_read_data(a_mrdata),
    .mem_hit_L1(a_mh1), .mem_hit_L2(a_mh2), .clear_cnt(a_clr),
    .cnt_hit_L1(a_c1), .cnt_hit_L2(a_c2), .cnt_miss(a_cm)
  );

  arbitro_hierarquia_memoria #(.ACCESS_CYCLES(3), .CNT_W(2)) u_b (
    .clock(clock), .reset(reset),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .done0(b_done0), .done1(b_done1), .rdata(b_rdata),
    .last_hit_L1(b_hl1), .last_hit_L2(b_hl2), .busy(b_busy),
    .mem_address(b_maddr), .mem_write_data(b_mwdata),
    .mem_read(b_mrd), .mem_write(b_mwr), .mem_read_data(b_mrdata),
    .mem_hit_L1(b_mh1), .mem_hit_L2(b_mh2), .clear_cnt(b_clr),
    .cnt_hit_L1(b_c1), .cnt_hit_L2(b_c2), .cnt_miss(b_cm)
  );

  // Hierarchy model for A: cold words read back as their own address,
  // any touched word becomes an L1 hit, force_l2 turns L1 misses into L2 hits.
  logic [63:0] l1v, wrv;
  logic [15:0] wmem [64];
  logic        force_l2;

  assign a_mrdata = wrv[a_maddr] ? wmem[a_maddr] : {10'd0, a_maddr};
  assign a_mh1    = l1v[a_maddr];
  assign a_mh2    = force_l2 & ~l1v[a_maddr];

  always @(posedge clock) begin
    if (!reset) begin
      l1v <= '0;
      wrv <= '0;
    end else if (a_mrd || a_mwr) begin
      l1v[a_maddr] <= 1'b1;
      if (a_mwr) begin
        wrv[a_maddr]  <= 1'b1;
        wmem[a_maddr] <= a_mwdata;
      end
    end
  end

  int n_a_done0 = 0;
  int n_a_done1 = 0;
  always @(posedge clock) begin
    if (a_done0) n_a_done0 <= n_a_done0 + 1;
    if (a_done1) n_a_done1 <= n_a_done1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    {a_req0, a_req1, a_we0, a_we1, a_clr} = '0;
    a_addr0 = '0; a_addr1 = '0; a_wdata0 = '0; a_wdata1 = '0;
    {b_req0, b_req1, b_we0, b_we1, b_clr} = '0;
    b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
    b_mrdata = 16'h5A5A; b_mh1 = 1'b0; b_mh2 = 1'b0;
    force_l2 = 1'b0;

    // Reset state
    tick; tick;
    check("rst_busy",  a_busy,  1'b0);
    check("rst_mrd",   a_mrd,   1'b0);
    check("rst_mwr",   a_mwr,   1'b0);
    check("rst_rdata", a_rdata, 16'h0);
    check("rst_maddr", a_maddr, 6'd0);
    check("rst_cnt",   {a_c1, a_c2, a_cm}, 24'h0);
    check("rst_done",  {a_done0, a_done1}, 2'b00);
    reset = 1'b1;

    // Cold read of address 1 by requester 0
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 6'd1;
    tick;
    check("t1_mrd",   a_mrd,   1'b1);
    check("t1_maddr", a_maddr, 6'd1);
    check("t1_busy",  a_busy,  1'b1);
    check("t1_done0_early", a_done0, 1'b0);
    tick;
    check("t1_done0", a_done0, 1'b1);
    check("t1_mrd_off", a_mrd, 1'b0);
    check("t1_rdata", a_rdata, 16'd1);
    check("t1_hits",  {a_hl1, a_hl2}, 2'b00);
    check("t1_miss",  a_cm, 8'd1);
    a_req0 = 1'b0;
    tick;
    check("t1_idle", {a_busy, a_done0}, 2'b00);

    // Repeat read: L1 hit
    a_req0 = 1'b1;
    tick; tick;
    check("t2_done0", a_done0, 1'b1);
    check("t2_rdata", a_rdata, 16'd1);
    check("t2_hl1",   a_hl1,   1'b1);
    check("t2_cl1",   a_c1,    8'd1);
    a_req0 = 1'b0;
    tick;
    check("t2_no_done1", n_a_done1, 0);

    // Both requesting: strict alternation 0,1,0,1
    a_req0 = 1'b1; a_addr0 = 6'd2;
    a_req1 = 1'b1; a_addr1 = 6'd3; a_we1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rr_addr", a_maddr, (i % 2) ? 6'd3 : 6'd2);
      tick;
      check("rr_done0", a_done0, (i % 2) ? 1'b0 : 1'b1);
      check("rr_done1", a_done1, (i % 2) ? 1'b1 : 1'b0);
      tick;
    end
    a_req0 = 1'b0; a_req1 = 1'b0;
    check("rr_n_done0", n_a_done0, 4);
    check("rr_n_done1", n_a_done1, 2);

    // Write by requester 1, then read it back by requester 0
    a_req1 = 1'b1; a_we1 = 1'b1; a_addr1 = 6'd4; a_wdata1 = 16'hABCD;
    tick;
    check("wr_mwr",    a_mwr,    1'b1);
    check("wr_mrd",    a_mrd,    1'b0);
    check("wr_maddr",  a_maddr,  6'd4);
    check("wr_mwdata", a_mwdata, 16'hABCD);
    tick;
    check("wr_done1",  a_done1, 1'b1);
    check("wr_rdata_kept", a_rdata, 16'd3);
    check("wr_mwr_off", a_mwr, 1'b0);
    a_req1 = 1'b0; a_we1 = 1'b0;
    tick;
    a_req0 = 1'b1; a_addr0 = 6'd4;
    tick; tick;
    check("rb_rdata", a_rdata, 16'hABCD);
    check("rb_hl1",   a_hl1,   1'b1);
    a_req0 = 1'b0;
    tick;

    // Address 63 served as an L2 hit
    force_l2 = 1'b1;
    a_req0 = 1'b1; a_addr0 = 6'd63;
    tick;
    check("a63_maddr", a_maddr, 6'd63);
    tick;
    check("a63_hits",  {a_hl1, a_hl2}, 2'b01);
    check("a63_rdata", a_rdata, 16'h003F);
    check("a63_cl2",   a_c2, 8'd1);
    a_req0 = 1'b0; force_l2 = 1'b0;
    tick;

    // Address 0 by requester 1
    a_req1 = 1'b1; a_addr1 = 6'd0;
    tick;
    check("a0_maddr", a_maddr, 6'd0);
    tick;
    check("a0_done1", a_done1, 1'b1);
    check("a0_rdata", a_rdata, 16'h0);
    a_req1 = 1'b0;
    tick;
    check("tot_miss", a_cm, 8'd5);
    check("tot_l1",   a_c1, 8'd4);
    check("tot_l2",   a_c2, 8'd1);
    a_clr = 1'b1;
    tick;
    a_clr = 1'b0;
    check("clr_a", {a_c1, a_c2, a_cm}, 24'h0);

    // B: three-cycle window, miss counter saturates at 3
    b_req0 = 1'b1; b_addr0 = 6'd9;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("sat_mrd_first", b_mrd, 1'b1);
      check("sat_maddr", b_maddr, 6'd9);
      tick; tick;
      check("sat_mrd_held", b_mrd, 1'b1);
      check("sat_done_early", b_done0, 1'b0);
      tick;
      check("sat_done0", b_done0, 1'b1);
      check("sat_mrd_off", b_mrd, 1'b0);
      check("sat_miss", b_cm, (k < 3) ? 2'(k + 1) : 2'd3);
      if (k == 0) check("sat_rdata", b_rdata, 16'h5A5A);
      if (k == 4) b_req0 = 1'b0;
      tick;
      check("sat_done_off", b_done0, 1'b0);
    end

    // Clear in the completing cycle wins over the increment
    b_req0 = 1'b1;
    tick; tick; tick;
    b_clr = 1'b1;
    tick;
    check("clr_done0", b_done0, 1'b1);
    check("clr_wins",  b_cm, 2'd0);
    b_clr = 1'b0; b_req0 = 1'b0;
    tick;

    // Contention moves rr to 0; reset mid-ISSUE restores it to 1
    b_req0 = 1'b1; b_addr0 = 6'd5;
    b_req1 = 1'b1; b_addr1 = 6'd6;
    tick;
    check("c_grant0", b_maddr, 6'd5);
    tick; tick; tick;
    check("c_done0", b_done0, 1'b1);
    check("c_miss",  b_cm, 2'd1);
    tick;
    tick;
    check("c_grant1", b_maddr, 6'd6);
    tick;
    check("c_mrd_before", b_mrd, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mr_mrd_async", b_mrd,  1'b0);
    check("mr_busy",      b_busy, 1'b0);
    check("mr_cnt",       {b_c1, b_c2, b_cm}, 6'd0);
    check("mr_maddr",     b_maddr, 6'd0);
    tick;
    check("mr_no_done", {b_done0, b_done1}, 2'b00);
    reset = 1'b1;
    tick;
    check("mr_first_grant", b_maddr, 6'd5);
    check("mr_first_mrd",   b_mrd,   1'b1);
    b_req0 = 1'b0; b_req1 = 1'b0;
    tick; tick; tick;
    check("mr_done0", b_done0, 1'b1);
    check("mr_miss",  b_cm, 2'd1);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
